// File: rtl/cpu_burst_sm.sv
// 68030-side DMA-master bus-cycle sequencer: N-beat longword bursts ended by STERM_, DSACK_ or BERR_, with a watchdog.
// Define SYNC_TERM_EN to honour STERM_; without it STERM_ is ignored and only DSACK_/BERR_/timeout terminate.
module cpu_burst_sm #(
  parameter int BEATS_MAX = 4,
  parameter int CNT_W     = 3,
  parameter int TIMEOUT   = 255,
  parameter int TO_W      = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_write,
  input  logic [CNT_W-1:0] i_beats,
  input  logic [1:0]       i_dsack_n,
  input  logic             i_sterm_n,
  input  logic             i_berr_n,
  output logic             o_as_n,
  output logic             o_ds_n,
  output logic             o_r_w,
  output logic             o_a1,
  output logic             o_latch,
  output logic             o_beat_done,
  output logic             o_done,
  output logic             o_err,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_beat_cnt
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ADDR = 3'd1;
  localparam logic [2:0] S_STRB = 3'd2;
  localparam logic [2:0] S_WAIT = 3'd3;
  localparam logic [2:0] S_TERM = 3'd4;
  localparam logic [2:0] S_END  = 3'd5;

  logic [2:0]       r_state;
  logic             r_write;
  logic [CNT_W-1:0] r_beats;
  logic [CNT_W-1:0] r_beat_cnt;
  logic             r_a1;
  logic             r_half;
  logic             r_err;
  logic [TO_W-1:0]  r_to_cnt;

  logic             w_berr;
  logic             w_sterm;
  logic             w_full_beat;
  logic             w_in_cycle;
  logic [CNT_W-1:0] w_cnt_inc;
  logic [CNT_W-1:0] w_beats_clamped;

  assign w_berr = ~i_berr_n;
`ifdef SYNC_TERM_EN
  assign w_sterm = ~i_sterm_n;
`else
  assign w_sterm = ~i_sterm_n & 1'b0;
`endif

  assign w_beats_clamped = (i_beats == '0 || i_beats > CNT_W'(BEATS_MAX)) ? CNT_W'(BEATS_MAX) : i_beats;
  assign w_cnt_inc       = r_beat_cnt + 1'b1;
  // The first half of a 16-bit beat only advances A1; every other termination completes a longword.
  assign w_full_beat     = !(r_half && !r_a1);
  assign w_in_cycle      = (r_state == S_ADDR) || (r_state == S_STRB) ||
                           (r_state == S_WAIT) || (r_state == S_TERM);

  // NOTE: all state uses non-blocking assignments so every branch sees pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_write    <= 1'b0;
      r_beats    <= '0;
      r_beat_cnt <= '0;
      r_a1       <= 1'b0;
      r_half     <= 1'b0;
      r_err      <= 1'b0;
      r_to_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (i_start) begin
          r_write    <= i_write;
          r_beats    <= w_beats_clamped;
          r_err      <= 1'b0;
          r_beat_cnt <= '0;
          r_a1       <= 1'b0;
          r_half     <= 1'b0;
          r_state    <= S_ADDR;
        end
        S_ADDR: begin
          if (w_berr) begin
            r_err   <= 1'b1;
            r_state <= S_END;
          end else begin
            r_state <= S_STRB;
          end
        end
        S_STRB: begin
          r_to_cnt <= '0;
          if (w_berr) begin
            r_err   <= 1'b1;
            r_state <= S_END;
          end else begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (w_berr) begin
            r_err   <= 1'b1;
            r_state <= S_END;
          end else if (w_sterm || i_dsack_n == 2'b00) begin
            r_half  <= 1'b0;
            r_state <= S_TERM;
          end else if (i_dsack_n == 2'b01) begin
            r_half  <= 1'b1;
            r_state <= S_TERM;
          end else if (i_dsack_n == 2'b10 || r_to_cnt == TO_W'(TIMEOUT - 1)) begin
            r_err   <= 1'b1;
            r_state <= S_END;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end
        S_TERM: begin
          if (w_berr) r_err <= 1'b1;
          if (w_full_beat) begin
            r_beat_cnt <= w_cnt_inc;
            r_a1       <= 1'b0;
            r_state    <= (w_cnt_inc == r_beats || w_berr) ? S_END : S_ADDR;
          end else begin
            r_a1    <= 1'b1;
            r_state <= w_berr ? S_END : S_ADDR;
          end
        end
        S_END:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_as_n      = !((r_state == S_STRB) || (r_state == S_WAIT));
  assign o_ds_n      = !((r_state == S_WAIT) || ((r_state == S_STRB) && !r_write));
  assign o_r_w       = w_in_cycle ? ~r_write : 1'b1;
  assign o_a1        = r_a1;
  assign o_latch     = (r_state == S_TERM);
  assign o_beat_done = (r_state == S_TERM) && w_full_beat;
  assign o_done      = (r_state == S_END);
  assign o_err       = r_err;
  assign o_busy      = (r_state != S_IDLE);
  assign o_beat_cnt  = r_beat_cnt;

endmodule

// File: tb/tb_cpu_burst_sm.sv
// Directed bench for cpu_burst_sm: a clock-level bus responder plus scoreboard queues for LATCH/A1, BEAT_DONE/BEAT_CNT and DONE/ERR.
module tb_cpu_burst_sm;

  localparam int BEATS_MAX = 4;
  localparam int CNT_W     = 3;
  localparam int TIMEOUT   = 255;
  localparam int TO_W      = 8;

  localparam int K_D32   = 0;
  localparam int K_D16   = 1;
  localparam int K_STERM = 2;
  localparam int K_NONE  = 3;
  localparam int K_D8    = 4;
  localparam int K_BERR  = 5;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             i_start;
  logic             i_write;
  logic [CNT_W-1:0] i_beats;
  logic [1:0]       i_dsack_n;
  logic             i_sterm_n;
  logic             i_berr_n;
  logic             o_as_n, o_ds_n, o_r_w, o_a1, o_latch, o_beat_done, o_done, o_err, o_busy;
  logic [CNT_W-1:0] o_beat_cnt;

  int n_chk = 0;
  int n_err = 0;
  int latch_q[$];
  int bd_q[$];
  int done_q[$];

  always #5 clk = ~clk;

  cpu_burst_sm #(
    .BEATS_MAX(BEATS_MAX), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .TO_W(TO_W)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(i_start), .i_write(i_write), .i_beats(i_beats),
    .i_dsack_n(i_dsack_n), .i_sterm_n(i_sterm_n), .i_berr_n(i_berr_n),
    .o_as_n(o_as_n), .o_ds_n(o_ds_n), .o_r_w(o_r_w), .o_a1(o_a1), .o_latch(o_latch),
    .o_beat_done(o_beat_done), .o_done(o_done), .o_err(o_err), .o_busy(o_busy),
    .o_beat_cnt(o_beat_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic bus_idle();
    i_start   = 1'b0;
    i_dsack_n = 2'b11;
    i_sterm_n = 1'b1;
    i_berr_n  = 1'b1;
  endtask

  function automatic logic [11:0] out_vec();
    return {o_as_n, o_ds_n, o_r_w, o_a1, o_latch, o_beat_done, o_done, o_err, o_busy, o_beat_cnt};
  endfunction

  // One burst: push expectations, start, answer each bus cycle after nwait wait clocks, score every output pulse.
  task automatic run_burst(input logic wr, input logic [CNT_W-1:0] beats, input int kind,
                           input int nwait, input int rst_at, output int done_clk);
    int  eff;
    int  exp_cnt;
    int  k;
    int  cyc;
    bit  sterm_ok;
    logic any_activity;
`ifdef SYNC_TERM_EN
    sterm_ok = 1'b1;
`else
    sterm_ok = 1'b0;
`endif
    eff = (int'(beats) == 0 || int'(beats) > BEATS_MAX) ? BEATS_MAX : int'(beats);
    latch_q.delete();
    bd_q.delete();
    done_q.delete();
    exp_cnt = 0;
    if (kind == K_D32 || (kind == K_STERM && sterm_ok)) begin
      for (int b = 0; b < eff; b++) begin
        latch_q.push_back(0);
        bd_q.push_back(b);
      end
      done_q.push_back(0);
      exp_cnt = eff;
    end else if (kind == K_D16) begin
      for (int b = 0; b < eff; b++) begin
        latch_q.push_back(0);
        latch_q.push_back(1);
        bd_q.push_back(b);
      end
      done_q.push_back(0);
      exp_cnt = eff;
    end else if (kind == K_BERR) begin
      latch_q.push_back(0);
      bd_q.push_back(0);
      done_q.push_back(1);
      exp_cnt = 1;
    end else begin
      done_q.push_back(1);
    end

    @(negedge clk);
    i_start = 1'b1;
    i_write = wr;
    i_beats = beats;
    done_clk = -1;
    k = 0;
    cyc = 0;
    for (int c = 1; c <= 600 && done_clk < 0; c++) begin
      @(negedge clk);
      i_start = 1'b0;
      if (c == rst_at) begin
        rst_n = 1'b0;
        bus_idle();
        #1;
        check("async_reset_outputs", 32'(out_vec()), 32'h0E00);
        any_activity = 1'b0;
        repeat (3) begin
          @(negedge clk);
          any_activity = any_activity | o_done | o_busy | o_latch;
        end
        check("reset_no_done", 32'(any_activity), 0);
        rst_n = 1'b1;
        latch_q.delete();
        bd_q.delete();
        done_q.delete();
        done_clk = 0;
        return;
      end
      if (c == 1) check("addr_phase", {o_busy, o_as_n, o_ds_n, o_err, o_r_w}, {1'b1, 1'b1, 1'b1, 1'b0, ~wr});
      if (c == 2) check("as_low_at_strb", 32'(o_as_n), 0);
      if (o_latch) begin
        if (latch_q.size() == 0) check("latch_unexpected", 1, 0);
        else check("latch_a1", 32'(o_a1), latch_q.pop_front());
      end
      if (o_beat_done) begin
        if (bd_q.size() == 0) check("beat_done_unexpected", 1, 0);
        else check("beat_done_cnt", 32'(o_beat_cnt), bd_q.pop_front());
      end
      if (o_done) begin
        if (done_q.size() == 0) check("done_unexpected", 1, 0);
        else check("done_err", 32'(o_err), done_q.pop_front());
        done_clk = c;
      end
      k = o_as_n ? 0 : k + 1;
      if (k == 1) check("ds_at_strb", 32'(o_ds_n), 32'(wr));
      bus_idle();
      if (k == 2 + nwait) begin
        case (kind)
          K_D32:   i_dsack_n = 2'b00;
          K_D16:   i_dsack_n = 2'b01;
          K_STERM: i_sterm_n = 1'b0;
          K_D8:    i_dsack_n = 2'b10;
          K_BERR: begin
            i_dsack_n = 2'b00;
            if (cyc == 1) begin
              i_berr_n  = 1'b0;
              i_sterm_n = 1'b0;
            end
          end
          default: ;
        endcase
        cyc++;
      end
    end
    bus_idle();
    if (done_clk < 0) begin
      check("done_within_budget", 0, 1);
    end else begin
      check("final_beat_cnt", 32'(o_beat_cnt), exp_cnt);
      check("scoreboard_drained", latch_q.size() + bd_q.size() + done_q.size(), 0);
    end
    @(negedge clk);
    check("back_to_idle", {o_busy, o_as_n, o_ds_n, o_done, o_latch}, 5'b01100);
  endtask

  initial begin
    int dc;
    int sterm_exp;
    rst_n   = 1'b0;
    i_write = 1'b0;
    i_beats = '0;
    bus_idle();
    repeat (2) @(negedge clk);
    check("reset_values", 32'(out_vec()), 32'h0E00);
    rst_n = 1'b1;
    @(negedge clk);

    run_burst(1'b0, 3'd4, K_D32, 0, 0, dc);
    check("read32_done_clock", dc, 17);

    run_burst(1'b1, 3'd2, K_D16, 2, 0, dc);
    check("write16_done_clock", dc, 25);

    run_burst(1'b0, 3'd0, K_D32, 0, 0, dc);
    check("beats0_clamp_done_clock", dc, 17);

    run_burst(1'b1, 3'd7, K_D32, 1, 0, dc);
    check("beats7_clamp_done_clock", dc, 21);

    run_burst(1'b0, 3'd3, K_NONE, 0, 0, dc);
    check("timeout_done_clock", dc, 3 + TIMEOUT);
    check("timeout_err_sticky", {o_err, o_as_n}, 2'b11);

    run_burst(1'b0, 3'd4, K_BERR, 0, 0, dc);
    check("berr_err_sticky", 32'(o_err), 1);

    run_burst(1'b1, 3'd2, K_D8, 0, 0, dc);
    check("dsack8_err_sticky", 32'(o_err), 1);

`ifdef SYNC_TERM_EN
    sterm_exp = 17;
`else
    sterm_exp = 3 + TIMEOUT;
`endif
    run_burst(1'b0, 3'd4, K_STERM, 0, 0, dc);
    check("sterm_done_clock", dc, sterm_exp);

    run_burst(1'b0, 3'd4, K_D32, 2, 16, dc);

    run_burst(1'b0, 3'd1, K_D32, 0, 0, dc);
    check("post_reset_single_beat", dc, 5);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
